// File: rtl/shift_sequencer_right.sv
// Multi-cycle right shifter: a STEP-bit fixed shifter plus a remaining-count register.
// Optional macro SHIFT_SEQUENCER_RIGHT_ABORT_EN adds an abort input that cancels BUSY/DONE.
module shift_sequencer_right #(
   parameter int  WIDTH     = 8,
   parameter int  STEP      = 1,
   parameter bit  PAD_VALUE = 1'b0,
   localparam int AMOUNT_WIDTH = $clog2(WIDTH + 1)
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [AMOUNT_WIDTH-1:0] in_amount,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    busy,
`ifdef SHIFT_SEQUENCER_RIGHT_ABORT_EN
   input  logic                    abort,
`endif
   output logic [1:0]              dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // the producer holds valid and data stable until that edge.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [AMOUNT_WIDTH-1:0] STEP_A  = AMOUNT_WIDTH'(STEP);
   localparam logic [AMOUNT_WIDTH-1:0] WIDTH_A = AMOUNT_WIDTH'(WIDTH);

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        data_q, data_d;
   logic [AMOUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [AMOUNT_WIDTH-1:0] step_amt;
   logic [AMOUNT_WIDTH-1:0] clamped_amount;
   logic                    abort_hit;

   function automatic logic [WIDTH-1:0] pad_shift(input logic [WIDTH-1:0]        v,
                                                  input logic [AMOUNT_WIDTH-1:0] amt);
      logic [WIDTH-1:0] fill;
      fill = ~({WIDTH{1'b1}} >> amt);
      return PAD_VALUE ? ((v >> amt) | fill) : (v >> amt);
   endfunction

`ifdef SHIFT_SEQUENCER_RIGHT_ABORT_EN
   assign abort_hit = abort && (state_q != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign clamped_amount = (in_amount > WIDTH_A) ? WIDTH_A : in_amount;
   // The last step consumes whatever is left, which may be smaller than STEP.
   assign step_amt       = (remaining_q > STEP_A) ? STEP_A : remaining_q;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         data_q      <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         remaining_q <= remaining_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      remaining_d = remaining_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d      = in_data;
               remaining_d = clamped_amount;
               state_d     = (clamped_amount == '0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            data_d      = pad_shift(data_q, step_amt);
            remaining_d = remaining_q - step_amt;
            if (remaining_q <= STEP_A) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort wins over both the shift step and a simultaneous output handshake.
      if (abort_hit) begin
         state_d     = IDLE;
         data_d      = data_q;
         remaining_d = '0;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = data_q;
   assign dbg_state = state_q;

endmodule
